// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - Dual-port (ifu/lsu) latency-modelled word memory responder.
// Optional MEM_RAND_DELAY_EN adds an LFSR-driven extra latency of 0..7 cycles per request.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned LATENCY     = 3,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_reqValid,
    input  logic [31:0] ifu_addr,
    output logic        ifu_respValid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_reqValid,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_respValid,
    output logic [31:0] lsu_rdata,
    output logic        protocol_err
);
`ifdef MEM_RAND_DELAY_EN
    localparam int CW = 5;
`else
    localparam int CW = 4;
`endif
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("mem_responder: LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        ifu_state, lsu_state;
    logic [CW-1:0] ifu_cnt, lsu_cnt, ifu_lat, lsu_lat;
    logic [31:0]   ifu_addr_q, lsu_addr_q, lsu_wdata_q;
    logic          lsu_wen_q;
    logic [3:0]    lsu_wmask_q;
    logic [31:0]   mem [DEPTH_WORDS];

`ifdef MEM_RAND_DELAY_EN
    logic [15:0] lfsr;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    assign ifu_lat = CW'(LATENCY) + {2'b00, lfsr[2:0]};
    assign lsu_lat = CW'(LATENCY) + {2'b00, lfsr[5:3]};
`else
    assign ifu_lat = CW'(LATENCY);
    assign lsu_lat = CW'(LATENCY);
`endif

    function automatic logic [31:0] word_idx(input logic [31:0] a);
        return (a - BASE_ADDR) >> 2;
    endfunction

    logic        ifu_accept, ifu_go_resp, ifu_viol, ifu_inr;
    logic        lsu_accept, lsu_go_resp, lsu_viol, lsu_inr;
    logic [31:0] ifu_idx, lsu_idx, lsu_acc_wdata;
    logic        lsu_acc_wen;
    logic [3:0]  lsu_acc_mask;

    assign ifu_accept  = ifu_reqValid && (ifu_state != WAIT);
    assign ifu_viol    = ifu_reqValid && (ifu_state == WAIT);
    assign ifu_go_resp = (ifu_accept && ifu_lat == CW'(1)) || (ifu_state == WAIT && ifu_cnt == CW'(1));
    // A request going straight to RESP is serviced from the live inputs, not the latch.
    assign ifu_idx     = word_idx((ifu_state == WAIT) ? ifu_addr_q : ifu_addr);
    assign ifu_inr     = ifu_idx < 32'(DEPTH_WORDS);

    assign lsu_accept    = lsu_reqValid && (lsu_state != WAIT);
    assign lsu_viol      = lsu_reqValid && (lsu_state == WAIT);
    assign lsu_go_resp   = (lsu_accept && lsu_lat == CW'(1)) || (lsu_state == WAIT && lsu_cnt == CW'(1));
    assign lsu_idx       = word_idx((lsu_state == WAIT) ? lsu_addr_q : lsu_addr);
    assign lsu_acc_wen   = (lsu_state == WAIT) ? lsu_wen_q   : lsu_wen;
    assign lsu_acc_wdata = (lsu_state == WAIT) ? lsu_wdata_q : lsu_wdata;
    assign lsu_acc_mask  = (lsu_state == WAIT) ? lsu_wmask_q : lsu_wmask;
    assign lsu_inr       = lsu_idx < 32'(DEPTH_WORDS);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ifu_state     <= IDLE;
            ifu_cnt       <= '0;
            ifu_addr_q    <= '0;
            ifu_respValid <= 1'b0;
            ifu_rdata     <= '0;
        end else begin
            ifu_respValid <= ifu_go_resp;
            if (ifu_go_resp) ifu_rdata <= ifu_inr ? mem[ifu_idx[AW-1:0]] : 32'hDEAD_BEEF;
            case (ifu_state)
                WAIT: begin
                    ifu_cnt <= ifu_cnt - 1'b1;
                    if (ifu_cnt == CW'(1)) ifu_state <= RESP;
                end
                default: begin
                    if (ifu_accept) begin
                        ifu_addr_q <= ifu_addr;
                        ifu_cnt    <= ifu_lat - 1'b1;
                        ifu_state  <= (ifu_lat == CW'(1)) ? RESP : WAIT;
                    end else begin
                        ifu_state  <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lsu_state     <= IDLE;
            lsu_cnt       <= '0;
            lsu_addr_q    <= '0;
            lsu_wdata_q   <= '0;
            lsu_wen_q     <= 1'b0;
            lsu_wmask_q   <= '0;
            lsu_respValid <= 1'b0;
            lsu_rdata     <= '0;
        end else begin
            lsu_respValid <= lsu_go_resp;
            if (lsu_go_resp && !lsu_acc_wen) lsu_rdata <= lsu_inr ? mem[lsu_idx[AW-1:0]] : 32'hDEAD_BEEF;
            case (lsu_state)
                WAIT: begin
                    lsu_cnt <= lsu_cnt - 1'b1;
                    if (lsu_cnt == CW'(1)) lsu_state <= RESP;
                end
                default: begin
                    if (lsu_accept) begin
                        lsu_addr_q  <= lsu_addr;
                        lsu_wdata_q <= lsu_wdata;
                        lsu_wen_q   <= lsu_wen;
                        lsu_wmask_q <= lsu_wmask;
                        lsu_cnt     <= lsu_lat - 1'b1;
                        lsu_state   <= (lsu_lat == CW'(1)) ? RESP : WAIT;
                    end else begin
                        lsu_state   <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) protocol_err <= 1'b0;
        else       protocol_err <= protocol_err | ifu_viol | lsu_viol;
    end

    // Array is deliberately left unreset; ifu reads on the same edge see pre-store data.
    always_ff @(posedge clock) begin
        if (!reset && lsu_go_resp && lsu_acc_wen && lsu_inr) begin
            for (int b = 0; b < 4; b++) begin
                if (lsu_acc_mask[b]) mem[lsu_idx[AW-1:0]][8*b +: 8] <= lsu_acc_wdata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - Directed self-checking bench for mem_responder.
module tb_mem_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ifu_reqValid = 1'b0;
    logic [31:0] ifu_addr = '0;
    logic        ifu_respValid;
    logic [31:0] ifu_rdata;
    logic        lsu_reqValid = 1'b0;
    logic [31:0] lsu_addr = '0;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_wdata = '0;
    logic [3:0]  lsu_wmask = '0;
    logic        lsu_respValid;
    logic [31:0] lsu_rdata;
    logic        protocol_err;

    int errors = 0;
    int checks = 0;

    mem_responder dut (
        .clock(clock), .reset(reset),
        .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
        .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata),
        .lsu_reqValid(lsu_reqValid), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata),
        .protocol_err(protocol_err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic lsu_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m, output int lat);
        lsu_reqValid = 1'b1; lsu_wen = w; lsu_addr = a; lsu_wdata = d; lsu_wmask = m;
        step();
        lsu_reqValid = 1'b0;
        lat = 1;
        while (!lsu_respValid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic ifu_txn(input logic [31:0] a, output int lat);
        ifu_reqValid = 1'b1; ifu_addr = a;
        step();
        ifu_reqValid = 1'b0;
        lat = 1;
        while (!ifu_respValid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int cnt;
        logic [31:0] held;
`ifdef MEM_RAND_DELAY_EN
        logic [31:0] model [16];
        logic [15:0] seen;
        int          distinct;
`endif
        step(); step(); step();
        chk("reset_ifu_respValid", 32'(ifu_respValid), 32'd0);
        chk("reset_lsu_respValid", 32'(lsu_respValid), 32'd0);
        chk("reset_ifu_rdata", ifu_rdata, 32'h0);
        chk("reset_lsu_rdata", lsu_rdata, 32'h0);
        chk("reset_protocol_err", 32'(protocol_err), 32'd0);
        reset = 1'b0;
        step();

`ifdef MEM_RAND_DELAY_EN
        for (int i = 0; i < 16; i++) begin
            model[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
            lsu_txn(1'b1, 32'h8000_0000 + 32'(i) * 4, model[i], 4'hF, lat);
        end
        seen = '0;
        for (int n = 0; n < 200; n++) begin
            logic [3:0]  wi;
            logic [31:0] d;
            logic [3:0]  m;
            logic [31:0] expd;
            wi = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                ifu_txn(32'h8000_0000 + 32'(wi) * 4, lat);
                chk("rand_ifu_rdata", ifu_rdata, model[wi]);
            end else if ($urandom_range(0, 1) == 0) begin
                d = $urandom();
                m = 4'($urandom_range(0, 15));
                lsu_txn(1'b1, 32'h8000_0000 + 32'(wi) * 4, d, m, lat);
                for (int b = 0; b < 4; b++)
                    if (m[b]) model[wi][8*b +: 8] = d[8*b +: 8];
            end else begin
                expd = model[wi];
                lsu_txn(1'b0, 32'h8000_0000 + 32'(wi) * 4, 32'h0, 4'h0, lat);
                chk("rand_lsu_rdata", lsu_rdata, expd);
            end
            checks++;
            assert (lat >= 3 && lat <= 10) else begin
                errors++;
                $error("FAIL rand_latency: observed %0d expected 3..10", lat);
            end
            if (lat >= 3 && lat <= 10) seen[lat] = 1'b1;
            step();
        end
        distinct = $countones(seen);
        checks++;
        assert (distinct >= 4) else begin
            errors++;
            $error("FAIL rand_distinct_latency: observed %0d expected >=4", distinct);
        end
`else
        lsu_txn(1'b1, 32'h8000_0000, 32'h0010_0093, 4'hF, lat);
        chk("preload0_latency", 32'(lat), 32'd3);
        lsu_txn(1'b1, 32'h8000_0004, 32'h1122_3344, 4'hF, lat);
        lsu_txn(1'b1, 32'h8000_0008, 32'h0000_0000, 4'hF, lat);
        step();

        // Fetch word 0: pulse exactly 3 cycles after the request, data held afterwards.
        ifu_reqValid = 1'b1; ifu_addr = 32'h8000_0000;
        step();
        ifu_reqValid = 1'b0;
        cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            if (ifu_respValid) cnt += (k == 3) ? 1 : 100;
            if (k == 3) chk("fetch_rdata", ifu_rdata, 32'h0010_0093);
            if (k < 10) step();
        end
        chk("fetch_pulse_only_at_t3", 32'(cnt), 32'd1);
        chk("fetch_rdata_held", ifu_rdata, 32'h0010_0093);

        lsu_txn(1'b0, 32'h8000_0000, 32'h0, 4'h0, lat);
        chk("load0_rdata", lsu_rdata, 32'h0010_0093);
        step();
        lsu_txn(1'b1, 32'h8000_0004, 32'hAABB_CCDD, 4'b0101, lat);
        chk("store_latency", 32'(lat), 32'd3);
        chk("store_keeps_lsu_rdata", lsu_rdata, 32'h0010_0093);
        step();
        lsu_txn(1'b0, 32'h8000_0004, 32'h0, 4'h0, lat);
        chk("masked_store_load", lsu_rdata, 32'h11BB_33DD);

        step();
        ifu_reqValid = 1'b1; ifu_addr = 32'h8000_0008;
        lsu_reqValid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_0008;
        lsu_wdata = 32'hFFFF_FFFF; lsu_wmask = 4'hF;
        step();
        ifu_reqValid = 1'b0; lsu_reqValid = 1'b0;
        step(); step();
        chk("same_cycle_ifu_resp", 32'(ifu_respValid), 32'd1);
        chk("same_cycle_lsu_resp", 32'(lsu_respValid), 32'd1);
        chk("same_cycle_ifu_pre_store", ifu_rdata, 32'h0);
        step();
        ifu_txn(32'h8000_0008, lat);
        chk("later_fetch_post_store", ifu_rdata, 32'hFFFF_FFFF);

        step();
        lsu_txn(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, lat);
        chk("oor_load_latency", 32'(lat), 32'd3);
        chk("oor_load_rdata", lsu_rdata, 32'hDEAD_BEEF);
        step();
        lsu_txn(1'b1, 32'h8000_4000, 32'h1234_5678, 4'hF, lat);
        chk("oor_store_latency", 32'(lat), 32'd3);
        step();
        lsu_txn(1'b0, 32'h8000_0000, 32'h0, 4'h0, lat);
        chk("oor_store_no_alias", lsu_rdata, 32'h0010_0093);
        step();
        lsu_txn(1'b1, 32'h8000_0004, 32'h0, 4'h0, lat);
        chk("zero_mask_latency", 32'(lat), 32'd3);
        step();
        lsu_txn(1'b0, 32'h8000_0004, 32'h0, 4'h0, lat);
        chk("zero_mask_no_change", lsu_rdata, 32'h11BB_33DD);

        // Back-to-back request accepted in the RESP cycle.
        step();
        ifu_txn(32'h8000_0000, lat);
        ifu_reqValid = 1'b1; ifu_addr = 32'h8000_0004;
        step();
        ifu_reqValid = 1'b0;
        step();
        chk("b2b_no_early_resp", 32'(ifu_respValid), 32'd0);
        step();
        chk("b2b_resp", 32'(ifu_respValid), 32'd1);
        chk("b2b_rdata", ifu_rdata, 32'h11BB_33DD);
        chk("b2b_no_violation", 32'(protocol_err), 32'd0);

        // Request while in WAIT: flagged and ignored.
        step();
        ifu_reqValid = 1'b1; ifu_addr = 32'h8000_0000;
        step();
        ifu_addr = 32'h8000_0008;
        chk("viol_err_not_yet", 32'(protocol_err), 32'd0);
        step();
        ifu_reqValid = 1'b0;
        chk("viol_err_set", 32'(protocol_err), 32'd1);
        cnt = 0;
        for (int k = 2; k <= 8; k++) begin
            if (ifu_respValid) cnt += (k == 3) ? 1 : 100;
            if (k == 3) chk("viol_pending_rdata", ifu_rdata, 32'h0010_0093);
            step();
        end
        chk("viol_single_resp", 32'(cnt), 32'd1);
        chk("viol_err_sticky", 32'(protocol_err), 32'd1);

        lsu_reqValid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0000;
        step();
        lsu_reqValid = 1'b0;
        reset = 1'b1;
        #1;
        chk("reset_async_err_clear", 32'(protocol_err), 32'd0);
        step();
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (lsu_respValid || ifu_respValid) cnt++;
        end
        chk("reset_discards_pending", 32'(cnt), 32'd0);
        chk("reset_err_cleared", 32'(protocol_err), 32'd0);
        chk("reset_lsu_rdata_cleared", lsu_rdata, 32'h0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
